// File: rtl/ladybird_gpio_debounce.sv
// Per-bit two-flop synchronizer plus stability-counter debouncer for board switches/buttons.
// Define LADYBIRD_DEBOUNCE_EVENT_EN to build the rise/fall/changed event outputs.
module ladybird_gpio_debounce #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned STABLE_CYCLES = 1000
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic [WIDTH-1:0] raw_in_i,
    output logic [WIDTH-1:0] db_out_o,
    output logic             ready_o
`ifdef LADYBIRD_DEBOUNCE_EVENT_EN
    ,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             changed_o
`endif
);

    localparam int unsigned CntW = ($clog2(STABLE_CYCLES) > 0) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax     = CntW'(STABLE_CYCLES - 1);
    localparam logic [16:0]     WarmTarget = 17'(STABLE_CYCLES + 2);

    logic [WIDTH-1:0]           sync1_q, sync2_q;
    logic [WIDTH-1:0]           db_q, db_d;
    logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
    logic [16:0]                wcnt_q, wcnt_d;
    logic                       ready_q, ready_d;

    // A bit follows its synchronized input only after STABLE_CYCLES consecutive disagreements.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    always_comb begin
        wcnt_d  = (wcnt_q == '1) ? wcnt_q : wcnt_q + 17'd1;
        ready_d = ready_q | (wcnt_q == WarmTarget);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            sync1_q <= raw_in_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            ready_q <= ready_d;
        end
    end

    assign db_out_o = db_q;
    assign ready_o  = ready_q;

`ifdef LADYBIRD_DEBOUNCE_EVENT_EN
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;

    // Flips during warm-up (including the reset settle) are deliberately silent.
    always_comb begin
        rise_d    = ready_q ? (db_d & ~db_q) : '0;
        fall_d    = ready_q ? (~db_d & db_q) : '0;
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign changed_o = changed_q;
`endif

endmodule

// File: tb/tb_ladybird_gpio_debounce.sv
// Scoreboard bench for ladybird_gpio_debounce with WIDTH=8, STABLE_CYCLES=4.
// Event outputs are checked only when LADYBIRD_DEBOUNCE_EVENT_EN is defined.
module tb_ladybird_gpio_debounce;

    logic       clk = 1'b0;
    logic       arst;
    logic [7:0] raw_in;
    logic [7:0] db_out;
    logic       ready;
`ifdef LADYBIRD_DEBOUNCE_EVENT_EN
    logic [7:0] rise;
    logic [7:0] fall;
    logic       changed;
`endif

    always #5 clk = ~clk;

    ladybird_gpio_debounce #(
        .WIDTH        (8),
        .STABLE_CYCLES(4)
    ) dut (
        .clk_i    (clk),
        .arst_i   (arst),
        .raw_in_i (raw_in),
        .db_out_o (db_out),
        .ready_o  (ready)
`ifdef LADYBIRD_DEBOUNCE_EVENT_EN
        ,
        .rise_o   (rise),
        .fall_o   (fall),
        .changed_o(changed)
`endif
    );

    typedef struct {
        int unsigned at;
        string       tag;
        logic [7:0]  db;
        logic        rdy;
        logic [7:0]  rs;
        logic [7:0]  fl;
        logic        chg;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        else n_pass++;
    endtask

    task automatic push_exp(input int unsigned d, input string tag, input logic [7:0] db,
                            input logic rdy, input logic [7:0] rs, input logic [7:0] fl,
                            input logic chg);
        exp_t e;
        e.at  = cyc + d;
        e.tag = tag;
        e.db  = db;
        e.rdy = rdy;
        e.rs  = rs;
        e.fl  = fl;
        e.chg = chg;
        sb_q.push_back(e);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Level change with the filter already settled: new value visible 6 edges later.
    task automatic step_to(input logic [7:0] nv, input logic [7:0] ov, input string tag);
        raw_in = nv;
        for (int k = 1; k <= 8; k++) begin
            push_exp(k, tag, (k >= 6) ? nv : ov, 1'b1,
                     (k == 6) ? (nv & ~ov) : 8'h00, (k == 6) ? (~nv & ov) : 8'h00,
                     (k == 6) && (nv != ov));
        end
        wait_neg(8);
    endtask

    // Monitor: compare scoreboard entries 1ns after the edge they belong to.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
            e = sb_q.pop_front();
            if (e.at < cyc) begin
                check_val({e.tag, "_stale"}, e.at, cyc);
            end else begin
                check_val({e.tag, "_db"}, db_out, e.db);
                check_val({e.tag, "_ready"}, ready, e.rdy);
`ifdef LADYBIRD_DEBOUNCE_EVENT_EN
                check_val({e.tag, "_rise"}, rise, e.rs);
                check_val({e.tag, "_fall"}, fall, e.fl);
                check_val({e.tag, "_changed"}, changed, e.chg);
`endif
            end
        end
    end

    initial begin
        arst   = 1'b1;
        raw_in = 8'hA5;
        @(negedge clk);
        push_exp(1, "in_reset", 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
        push_exp(2, "in_reset", 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
        wait_neg(3);

        // Release with A5 held: settles on edge 6, ready on edge 7, no events.
        arst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            push_exp(k, "warmup", (k >= 6) ? 8'hA5 : 8'h00, k >= 7, 8'h00, 8'h00, 1'b0);
        end
        wait_neg(8);

        step_to(8'hA4, 8'hA5, "b0_fall");
        step_to(8'hA5, 8'hA4, "b0_rise");
        step_to(8'h0F, 8'hA5, "to_0f");
        step_to(8'hF0, 8'h0F, "swap");

        // 3-cycle glitch on bit 3 is filtered out.
        raw_in = 8'hF8;
        for (int k = 1; k <= 10; k++) push_exp(k, "glitch3", 8'hF0, 1'b1, 8'h00, 8'h00, 1'b0);
        wait_neg(3);
        raw_in = 8'hF0;
        wait_neg(7);

        // 4-cycle pulse is exactly long enough to pass, then filters back out.
        raw_in = 8'hF8;
        for (int k = 1; k <= 12; k++) begin
            push_exp(k, "pulse4", (k >= 6 && k < 10) ? 8'hF8 : 8'hF0, 1'b1,
                     (k == 6) ? 8'h08 : 8'h00, (k == 10) ? 8'h08 : 8'h00, (k == 6) || (k == 10));
        end
        wait_neg(4);
        raw_in = 8'hF0;
        wait_neg(8);

        // Reset while bit 2 is mid-count: immediate clear, pending flip never emitted.
        raw_in = 8'hF4;
        wait_neg(4);
        arst = 1'b1;
        #1;
        check_val("mid_rst_db", db_out, 8'h00);
        check_val("mid_rst_ready", ready, 1'b0);
`ifdef LADYBIRD_DEBOUNCE_EVENT_EN
        check_val("mid_rst_rise", rise, 8'h00);
        check_val("mid_rst_fall", fall, 8'h00);
        check_val("mid_rst_changed", changed, 1'b0);
`endif
        push_exp(1, "mid_rst_hold", 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
        push_exp(2, "mid_rst_hold", 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
        wait_neg(2);
        arst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            push_exp(k, "rewarm", (k >= 6) ? 8'hF4 : 8'h00, k >= 7, 8'h00, 8'h00, 1'b0);
        end
        wait_neg(8);

        step_to(8'hF5, 8'hF4, "post_rst_rise");

        wait_neg(2);
        check_val("sb_drain", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
